// File: rtl/mac_pe_acc.sv
// Multi-lane multiply-accumulate PE: per-lane products, lane reduction, windowed accumulation, valid/ready result.
// Optional: define MAC_PE_SAT_EN for unsigned-saturating accumulation with a sticky per-window sat_flag.
module mac_pe_acc #(
  parameter int unsigned IN_BITWIDTH  = 16,
  parameter int unsigned LANES        = 4,
  parameter int unsigned ACC_BITWIDTH = 2*IN_BITWIDTH+8,
  parameter int unsigned MAX_ACC_LEN  = 16,
  parameter int unsigned LEN_W        = $clog2(MAX_ACC_LEN+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [LEN_W-1:0]             acc_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_BITWIDTH-1:0] a_in,
  input  logic [LANES*IN_BITWIDTH-1:0] w_in,
  input  logic [ACC_BITWIDTH-1:0]      psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_BITWIDTH-1:0]      psum_out,
  output logic                         sat_flag
);

  localparam int unsigned PW = 2*IN_BITWIDTH;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                         state_q, state_d;
  logic [LEN_W-1:0]               len_q, len_d, cnt_q, cnt_d, eff_len;
  logic                           adv, accept, beat_first, beat_last;
  logic                           s1_valid, s1_first, s1_last;
  logic [LANES-1:0][PW-1:0]       prod_q;
  logic [ACC_BITWIDTH-1:0]        psum_q, acc_q, acc_d, tree, base;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign accept   = in_valid && in_ready && !clear;

  always_comb begin
    eff_len = acc_len;
    if (acc_len == '0)
      eff_len = LEN_W'(1);
    else if (acc_len > LEN_W'(MAX_ACC_LEN))
      eff_len = LEN_W'(MAX_ACC_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          beat_first = 1'b1;
          len_d      = eff_len;
          cnt_d      = LEN_W'(1);
          if (eff_len == LEN_W'(1)) beat_last = 1'b1;
          else                      state_d   = S_ACC;
        end
        S_ACC: begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            beat_last = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Stage 1: products plus window tags; psum_in rides along only for the first beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      prod_q   <= '0;
      psum_q   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= beat_first;
        s1_last  <= beat_last;
        for (int unsigned i = 0; i < LANES; i++)
          prod_q[i] <= PW'(a_in[i*IN_BITWIDTH +: IN_BITWIDTH]) * PW'(w_in[i*IN_BITWIDTH +: IN_BITWIDTH]);
        if (beat_first) psum_q <= psum_in;
      end
    end
  end

  // ACC_BITWIDTH covers the full lane sum, so the reduction itself cannot overflow
  always_comb begin
    tree = '0;
    for (int unsigned i = 0; i < LANES; i++)
      tree = tree + ACC_BITWIDTH'(prod_q[i]);
  end

  assign base = s1_first ? psum_q : acc_q;

`ifdef MAC_PE_SAT_EN
  logic [ACC_BITWIDTH:0] sum_ext;
  logic                  sat_acc_q, sat_d, sat_out_q;

  assign sum_ext  = {1'b0, base} + {1'b0, tree};
  assign acc_d    = sum_ext[ACC_BITWIDTH] ? '1 : sum_ext[ACC_BITWIDTH-1:0];
  assign sat_d    = (s1_first ? 1'b0 : sat_acc_q) | sum_ext[ACC_BITWIDTH];
  assign sat_flag = sat_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc_q <= 1'b0;
      sat_out_q <= 1'b0;
    end else if (clear) begin
      sat_acc_q <= 1'b0;
    end else if (adv && s1_valid) begin
      sat_acc_q <= sat_d;
      if (s1_last) sat_out_q <= sat_d;
    end
  end
`else
  assign acc_d    = base + tree;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      psum_out  <= '0;
    end else if (clear) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        acc_q <= acc_d;
        if (s1_last) psum_out <= acc_d;
      end
    end
  end

endmodule

// File: doc/mac_pe_acc.md
Name: mac_pe_acc

Overview:
- Parametrised multi-lane multiply-accumulate processing element; successor to the single-lane 16x16 MAC.
- Each accepted beat multiplies LANES activation/weight pairs, reduces them with an adder tree, and accumulates the sum over a programmable window of beats.
- At window end it adds an incoming partial sum and emits one result over a valid/ready handshake.
- Sits in the PE array between the scratchpads (activation/weight feed) and the vertical psum chain.

Parameters:
- IN_BITWIDTH, 16, width of each activation and weight element (unsigned).
- LANES, 4, multiplier lanes per beat (>=1).
- ACC_BITWIDTH, 2*IN_BITWIDTH+8, accumulator, psum_in and psum_out width (>= 2*IN_BITWIDTH+$clog2(LANES)).
- MAX_ACC_LEN, 16, maximum beats per accumulation window.
- LEN_W, $clog2(MAX_ACC_LEN+1), width of acc_len.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: empties pipeline and returns to IDLE.
- acc_len  in  LEN_W  beats per window; sampled on the first beat of each window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- a_in  in  LANES*IN_BITWIDTH  packed activations; lane i at [i*IN_BITWIDTH +: IN_BITWIDTH].
- w_in  in  LANES*IN_BITWIDTH  packed weights, same packing.
- psum_in  in  ACC_BITWIDTH  partial sum; sampled on the first beat of a window only.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- psum_out  out  ACC_BITWIDTH  accumulated result.
- sat_flag  out  1  result saturated (tied 0 when the optional feature is absent).

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0 (in_ready reads 0 while rst_n=0, then 1).
  - FSM in IDLE; accumulator, beat counter and pipeline valids cleared.
- Advance and handshake:
  - adv = !out_valid || out_ready.
  - All pipeline registers update only when adv=1; in_ready = adv and rst_n.
  - A beat is accepted when in_valid && in_ready.
  - out_valid/psum_out stay stable until out_valid && out_ready.
- Stage 1 (registered): per-lane unsigned products, 2*IN_BITWIDTH bits each; beat tags first and last.
- Stage 2: adder tree sums the lanes at full width, zero-extended to ACC_BITWIDTH.
  - first beat: acc = psum_in_reg + tree.
  - otherwise: acc = acc + tree.
  - On the last beat the acc result is loaded into psum_out and out_valid=1.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+2 when unstalled. Throughput 1 beat/cycle; back-to-back windows need no bubble.
- FSM (beat-count side, state changes only on accepted beats):
  - IDLE: on a beat, latch len = max(acc_len,1) and psum_in, tag the beat first, set cnt=1. If len==1, tag it last and stay in IDLE; else go to ACC.
  - ACC: on a beat, cnt++. When cnt reaches len, tag the beat last and go to IDLE.
  - acc_len and psum_in are ignored outside the first beat.
- Boundaries:
  - acc_len=0 is treated as 1.
  - acc_len > MAX_ACC_LEN is clamped to MAX_ACC_LEN.
  - in_valid=0 mid-window leaves the window open indefinitely.
  - Output accepted in the same cycle a new result arrives: new result loads and out_valid stays 1.
- Arithmetic: without the optional feature, accumulation wraps modulo 2^ACC_BITWIDTH.
- clear: takes priority over everything.
  - Next cycle: FSM IDLE, stage valids 0, out_valid 0, accumulator 0.
  - Any beat presented in the clear cycle is dropped.

Optional Feature:
- Macro: MAC_PE_SAT_EN.
- Defined:
  - Every accumulate add is unsigned-saturating; on overflow acc = 2^ACC_BITWIDTH-1 and a sticky window flag is set.
  - sat_flag is presented with the result and has the same valid/hold timing as psum_out.
  - The sticky flag clears on the first beat of the next window.
- Undefined: wrap-around arithmetic, sat_flag tied 0, no saturation logic.

Test Plan:
- Single-beat window: acc_len=1, LANES=4, a={1,2,3,4}, w={5,6,7,8}, psum_in=10, out_ready=1 -> out_valid at t+2 with psum_out=80, pulse of 1 cycle.
- Four-beat window: acc_len=4, all a=w=lanes value 2, psum_in=0, continuous beats -> one result of 64 at last beat +2; in_ready held 1 throughout.
- Backpressure: out_ready=0 for 5 cycles while a result is pending -> in_ready=0, psum_out stable; release -> next window continues without loss or duplication.
- Boundary: acc_len=0 behaves as acc_len=1; acc_len=31 with MAX_ACC_LEN=16 produces a result after exactly 16 beats.
- Clear mid-window: clear after beat 2 of 4 -> no output; a following window with acc_len=1, a=w={3,0,0,0}, psum_in=0 -> psum_out=9.
- Overflow: ACC_BITWIDTH=32, psum_in=0xFFFF_FFF0, product sum 0x20 -> with MAC_PE_SAT_EN psum_out=0xFFFF_FFFF and sat_flag=1; without it psum_out=0x10 and sat_flag=0.
